decode_issue_buffer: RTL

//  Elastic FIFO between the decoder (id_stage) and the scoreboard issue port.

---
 rtl/decode_issue_buffer_pkg.sv | 16 +
 rtl/decode_issue_buffer_if.sv | 26 ++
 rtl/decode_issue_buffer.sv | 95 +++++++++
 3 files changed

// File: rtl/decode_issue_buffer_pkg.sv
// Package for the decode/issue buffer.
// Holds the decoded scoreboard entry type and the default buffer depth
// used by the instantiating stage.
package decode_issue_buffer_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [7:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
  } scoreboard_entry_t;

  localparam int unsigned DECODE_BUF_DEPTH = 4;

endpackage

// File: rtl/decode_issue_buffer_if.sv
// Handshake bundle between decoder, buffer and scoreboard issue port.
// Signal suffixes are from the buffer's point of view.
//   slave  : the buffer (accepts decoded entries, presents oldest entry)
//   master : the surrounding pipeline (decoder + scoreboard)
interface decode_issue_buffer_if;
  import decode_issue_buffer_pkg::*;

  scoreboard_entry_t decoded_instr_i;
  logic              is_ctrl_flow_i;
  logic              decoded_instr_valid_i;
  logic              decoded_instr_ack_o;
  scoreboard_entry_t issue_instr_o;
  logic              issue_is_ctrl_flow_o;
  logic              issue_instr_valid_o;
  logic              issue_instr_ack_i;

  modport slave (
    input  decoded_instr_i, is_ctrl_flow_i, decoded_instr_valid_i, issue_instr_ack_i,
    output decoded_instr_ack_o, issue_instr_o, issue_is_ctrl_flow_o, issue_instr_valid_o
  );

  modport master (
    output decoded_instr_i, is_ctrl_flow_i, decoded_instr_valid_i, issue_instr_ack_i,
    input  decoded_instr_ack_o, issue_instr_o, issue_is_ctrl_flow_o, issue_instr_valid_o
  );
endinterface

// File: rtl/decode_issue_buffer.sv
// Elastic FIFO between the decoder and the scoreboard issue port.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   flush_i, flush_unissued_instr_i : drop every buffered entry
//   bus     : decode_issue_buffer_if.slave (decode push / issue pop handshakes)
//   usage_o : occupancy 0..DEPTH; full_o / empty_o decoded from it
// Optional feature: define DECODE_BUF_BYPASS_EN to forward an incoming entry
// to the issue port in the same cycle while the buffer is empty.
module decode_issue_buffer
  import decode_issue_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = DECODE_BUF_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     flush_unissued_instr_i,
  decode_issue_buffer_if.slave     bus,
  output logic [$clog2(DEPTH):0]   usage_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  typedef struct packed {
    logic              is_ctrl_flow;
    scoreboard_entry_t instr;
  } buf_entry_t;

  buf_entry_t        mem_q [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0]   count_q, count_d;

  logic flush;
  logic bypass;
  logic push_mem;
  logic pop_mem;

  always_comb begin
    flush   = flush_i | flush_unissued_instr_i;
    full_o  = (count_q == DepthCnt);
    empty_o = (count_q == '0);
    usage_o = count_q;

    // Deliberately independent of issue_instr_ack_i: no ack-to-ack comb path.
    bus.decoded_instr_ack_o = !full_o && !flush;

`ifdef DECODE_BUF_BYPASS_EN
    bypass = empty_o && bus.decoded_instr_valid_i && !flush;
`else
    bypass = 1'b0;
`endif

    bus.issue_instr_valid_o  = !empty_o || bypass;
    bus.issue_instr_o        = bypass ? bus.decoded_instr_i : mem_q[rd_ptr_q].instr;
    bus.issue_is_ctrl_flow_o = bypass ? bus.is_ctrl_flow_i : mem_q[rd_ptr_q].is_ctrl_flow;

    // A bypassed entry consumed in the same cycle never touches storage.
    push_mem = bus.decoded_instr_valid_i && bus.decoded_instr_ack_o &&
               !(bypass && bus.issue_instr_ack_i);
    pop_mem  = !empty_o && bus.issue_instr_ack_i;

    count_d = count_q;
    if (push_mem && !pop_mem) begin
      count_d = count_q + CntW'(1);
    end else if (!push_mem && pop_mem) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_mem) begin
        mem_q[wr_ptr_q] <= '{is_ctrl_flow: bus.is_ctrl_flow_i, instr: bus.decoded_instr_i};
        wr_ptr_q        <= wr_ptr_q + PtrW'(1);
      end
      if (pop_mem) begin
        rd_ptr_q <= rd_ptr_q + PtrW'(1);
      end
      count_q <= count_d;
    end
  end

endmodule
